bcd_serial_adder: RTL and testbench
===================================

# bcd_serial_adder

Digit-serial multi-digit BCD adder: accepts two packed DIGITS-wide BCD operands plus a carry-in on a start strobe and adds them one decimal digit per clock, least-significant digit first. It reuses a combinational single-digit BCD add/correct stage and wraps it in a sequencer with a carry register and result shift register. It sits directly upstream of the display/consumer logic. It extends the single-digit BCD add to arbitrary width at one digit-adder's area cost.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  4*DIGITS  operand A, packed BCD, digit 0 = bits [3:0]
- b  in  4*DIGITS  operand B, same packing
- cin  in  1  decimal carry into digit 0
- busy  out  1  high while a sum is in progress (ADD state)
- done  out  1  one-cycle pulse when sum/cout/err are valid
- sum  out  4*DIGITS  packed BCD result; held until next accepted start
- cout  out  1  decimal carry out of the most-significant digit
- err  out  1  set if any operand digit > 9 was consumed

## Operation
- States: IDLE, ADD, DONE.
- IDLE: start=1 latches a, b, cin into internal operand registers; clears the digit index, the result register and err; goes to ADD. start=0 remains in IDLE.
- ADD: each cycle processes digit i = index:
  - t = a_i + b_i + c (5-bit), where c = carry register (cin for i=0).
  - If t > 9: digit = (t + 6) mod 16 and carry = 1. Otherwise digit = t and carry = 0.
  - The digit is written to sum slot i. The carry register updates.
  - err |= (a_i > 9) | (b_i > 9).
  - After digit DIGITS-1, cout takes the final carry and the state goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- sum, cout and err hold their values in IDLE until the next accepted start.
- Invalid digits are not rejected. They are computed by the same rule and flagged with err.
- start while busy or in DONE is ignored. It is not queued.
- Operand inputs are don't-care except in the cycle start is accepted.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, err=0, carry and index = 0.
- Reset is asynchronous and takes effect mid-operation. The partial result is discarded and no done is issued.
- Start accepted at edge N gives:
  - busy=1 from N+1 through N+DIGITS.
  - done=1 in cycle N+DIGITS+1.
  - sum, cout and err are valid from N+DIGITS+1 on.
- Latency is DIGITS+1 cycles from accepting edge to done. Throughput is one sum per DIGITS+2 cycles; start may be asserted in the cycle after done.
- The combinational digit path is a 4-bit add, a >9 compare and a +6 correct. All outputs are registered.

## Structure
- Shared package bcd_pkg holds:
  - the state enum (IDLE/ADD/DONE);
  - the constants BCD_MAX=9 and BCD_CORR=6;
  - the digit width 4.
- One sub-module, bcd_digit_adder (combinational):
  - inputs: 4-bit x, 4-bit y, 1-bit ci;
  - outputs: 4-bit s, 1-bit co, 1-bit bad (x>9 or y>9).
- The top level holds the FSM, the index counter, the carry flop, the operand registers and the result register.

## Test plan
- DIGITS=4, a=0x1234, b=0x5678, cin=0, start at edge 0 → busy cycles 1–4, done cycle 5, sum=0x6912, cout=0, err=0.
- a=0x9999, b=0x0001, cin=0 → sum=0x0000, cout=1. Also a=0x0000, b=0x0000, cin=1 → sum=0x0001, cout=0.
- a=0x000A, b=0x0000, cin=0 → err=1, sum=0x0010, cout=0. Then a valid sum (0x0001+0x0001 → 0x0002) gives err=0.
- start held high continuously with a=0x0005, b=0x0005 → done every 6 cycles, sum=0x0010. Pulses of start during busy do not alter sum or restart the sequence.
- Assert rst during cycle 2 of ADD → busy, done, sum, cout and err are all 0 immediately with no done pulse. Then a=0x4321, b=0x1111 gives sum=0x5432 with normal latency.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD adder: sequencer states and
// decimal constants used by the digit stage.
package bcd_pkg;

  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned BCD_MAX  = 9;
  localparam int unsigned BCD_CORR = 6;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_e;

endpackage

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit BCD add with decimal correction; flags any
// operand nibble outside 0..9 without altering the arithmetic.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               ci,
  output logic [DIGIT_W-1:0] s,
  output logic               co,
  output logic               bad
);

  localparam int unsigned T_W = DIGIT_W + 1;

  logic [T_W-1:0] t;

  always_comb begin
    t   = T_W'(x) + T_W'(y) + T_W'(ci);
    co  = (t > T_W'(BCD_MAX));
    s   = co ? DIGIT_W'(t + T_W'(BCD_CORR)) : t[DIGIT_W-1:0];
    bad = (x > DIGIT_W'(BCD_MAX)) | (y > DIGIT_W'(BCD_MAX));
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder: one decimal digit per clock, LSD first,
// sharing a single digit stage across all DIGITS positions.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DIGIT_W*DIGITS-1:0] a,
  input  logic [DIGIT_W*DIGITS-1:0] b,
  input  logic                      cin,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] sum,
  output logic                      cout,
  output logic                      err
);

  localparam int unsigned W     = DIGIT_W * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       sum_q;
  logic               cout_q;
  logic               err_q;
  logic               busy_q;
  logic               done_q;

  logic [DIGIT_W-1:0] dig_s;
  logic               dig_co;
  logic               dig_bad;

  // Operand registers shift right each step, so the stage always sees digit 0.
  bcd_digit_adder u_digit (
    .x   (a_q[DIGIT_W-1:0]),
    .y   (b_q[DIGIT_W-1:0]),
    .ci  (carry_q),
    .s   (dig_s),
    .co  (dig_co),
    .bad (dig_bad)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ADD;
          end
        end
        ADD: begin
          for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) sum_q[k*DIGIT_W +: DIGIT_W] <= dig_s;
          end
          a_q     <= a_q >> DIGIT_W;
          b_q     <= b_q >> DIGIT_W;
          carry_q <= dig_co;
          err_q   <= err_q | dig_bad;
          if (idx_q == LAST_IDX) begin
            cout_q  <= dig_co;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder: decimal reference model with
// cycle-level compare, directed literal cases and randomized traffic.
module tb_bcd_serial_adder;

  localparam int unsigned D = 4;
  localparam int unsigned W = 4 * D;

  logic         clk   = 1'b0;
  logic         rst   = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         cin   = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  int n_checks = 0;
  int n_pass   = 0;

  bcd_serial_adder #(.DIGITS(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: plain decimal arithmetic when all digits are valid, otherwise
  // the per-digit add/+6 rule applied to raw nibbles.
  function automatic void ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                                  output logic [W-1:0] s, output logic co, output logic bad);
    longint xv, yv, tot, p;
    int dx, dy, t, carry;
    logic [W-1:0] xx, yy;
    xx = x; yy = y;
    xv = 0; yv = 0; p = 1; bad = 1'b0; s = '0;
    for (int i = 0; i < int'(D); i++) begin
      dx = int'(xx[4*i +: 4]);
      dy = int'(yy[4*i +: 4]);
      if (dx > 9 || dy > 9) bad = 1'b1;
      xv += longint'(dx) * p;
      yv += longint'(dy) * p;
      p  *= 10;
    end
    if (!bad) begin
      tot = xv + yv + longint'(c);
      co  = (tot >= p);
      tot = tot % p;
      for (int i = 0; i < int'(D); i++) begin
        s[4*i +: 4] = 4'(tot % 10);
        tot = tot / 10;
      end
    end else begin
      carry = int'(c);
      for (int i = 0; i < int'(D); i++) begin
        t = int'(xx[4*i +: 4]) + int'(yy[4*i +: 4]) + carry;
        if (t > 9) begin
          s[4*i +: 4] = 4'((t + 6) % 16);
          carry = 1;
        end else begin
          s[4*i +: 4] = 4'(t);
          carry = 0;
        end
      end
      co = (carry != 0);
    end
  endfunction

  // Transaction-level timing model: phase 0 idle, 1..D busy, D+1 done.
  int unsigned  m_phase = 0;
  logic [W-1:0] pa = '0, pb = '0;
  logic         pcin = 1'b0;
  logic         e_busy = 1'b0, e_done = 1'b0, e_cout = 1'b0, e_err = 1'b0;
  logic [W-1:0] e_sum = '0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_phase = 0; e_busy = 1'b0; e_done = 1'b0;
      e_sum = '0; e_cout = 1'b0; e_err = 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        pa = a; pb = b; pcin = cin;
        e_busy = 1'b1; e_sum = '0; e_cout = 1'b0; e_err = 1'b0;
        m_phase = 1;
      end
    end else if (m_phase < D) begin
      m_phase++;
    end else if (m_phase == D) begin
      ref_add(pa, pb, pcin, e_sum, e_cout, e_err);
      e_busy = 1'b0; e_done = 1'b1;
      m_phase = D + 1;
    end else begin
      e_done = 1'b0;
      m_phase = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(e_done));
    if (m_phase == 0 || m_phase == D + 1) begin
      check("sum", 32'(sum), 32'(e_sum));
      check("cout", 32'(cout), 32'(e_cout));
      check("err", 32'(err), 32'(e_err));
    end
  end

  task automatic drive(input logic s, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    @(posedge clk);
    #2;
    start = s; a = x; b = y; cin = c;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic txn(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                     input logic [W-1:0] xs, input logic xc, input logic xe, input string nm);
    bit ok;
    drive(1'b1, x, y, c);
    drive(1'b0, '0, '0, 1'b0);
    wait_done(ok);
    check({nm, "_done_seen"}, 32'(ok), 32'd1);
    check({nm, "_sum"}, 32'(sum), 32'(xs));
    check({nm, "_cout"}, 32'(cout), 32'(xc));
    check({nm, "_err"}, 32'(err), 32'(xe));
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    v = '0;
    if ($urandom_range(0, 9) == 0) return {D{4'h9}};
    for (int i = 0; i < int'(D); i++) begin
      if ($urandom_range(0, 7) == 0) v[4*i +: 4] = 4'($urandom_range(0, 15));
      else v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  initial begin
    bit ok;
    int ndone, first_d, last_d;

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    txn(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, "basic");
    txn(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple");
    txn(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, "cin_only");
    txn(16'h000A, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b1, "bad_digit");
    txn(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "err_clear");

    // A start pulse while busy must neither restart nor alter the sum.
    drive(1'b1, 16'h1234, 16'h5678, 1'b0);
    drive(1'b0, '0, '0, 1'b0);
    drive(1'b1, 16'h9999, 16'h9999, 1'b1);
    drive(1'b0, '0, '0, 1'b0);
    wait_done(ok);
    check("busy_pulse_done_seen", 32'(ok), 32'd1);
    check("busy_pulse_sum", 32'(sum), 32'h6912);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("busy_pulse_no_extra_done", 32'(ndone), 32'd0);

    // Continuous start: one sum every D+2 cycles.
    drive(1'b1, 16'h0005, 16'h0005, 1'b0);
    ndone = 0; first_d = -1; last_d = -1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first_d < 0) first_d = i;
        last_d = i;
      end
    end
    check("hold_done_count", 32'(ndone), 32'd4);
    check("hold_done_span", 32'(last_d - first_d), 32'd18);
    check("hold_sum", 32'(sum), 32'h0010);
    drive(1'b0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);

    // Reset in the second ADD cycle discards the partial result.
    drive(1'b1, 16'h9876, 16'h5555, 1'b1);
    drive(1'b0, '0, '0, 1'b0);
    @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rst_no_done", 32'(ndone), 32'd0);
    txn(16'h4321, 16'h1111, 1'b0, 16'h5432, 1'b0, 1'b0, "after_rst");

    // Randomized traffic with occasional resets; the model checks every cycle.
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #2;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      start = ($urandom_range(0, 3) == 0);
      a     = rand_bcd();
      b     = rand_bcd();
      cin   = 1'($urandom_range(0, 1));
    end
    drive(1'b0, '0, '0, 1'b0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
